// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg
//   Shared types for the pipeline-stage register.
//   - STATE_W      : width of the stage state encoding
//   - pipe_state_e : occupancy of the stage
//       PIPE_EMPTY : nothing held
//       PIPE_BUSY  : main entry valid
//       PIPE_FULL  : main and skid entries valid (skid build only)
//   Build option: PIPE_REG_SKID_EN (see pipe_reg.sv).
package pipe_reg_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_BUSY  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

endpackage : pipe_reg_pkg

// File: rtl/pipe_reg_if.sv
// pipe_reg_if
//   One valid/ready/data channel between two pipeline stages.
//   Parameters:
//     WIDTH : payload width in bits
//   Signals:
//     valid : producer holds a beat
//     ready : consumer can take the beat
//     data  : payload
//   Modports:
//     master : producer side (drives valid/data, samples ready)
//     slave  : consumer side (samples valid/data, drives ready)
interface pipe_reg_if #(
  parameter int WIDTH = 32
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface : pipe_reg_if

// File: rtl/pipe_reg_slot.sv
// pipe_reg_slot
//   WIDTH-bit data register with load enable and asynchronous,
//   active-high reset to RESET_VAL. Used for the main entry and, in the
//   skid build, the skid entry of pipe_reg.
//   Ports:
//     clk  : rising-edge clock
//     rst  : async active-high reset
//     i_ld : load enable
//     i_d  : data to load
//     o_q  : registered data
module pipe_reg_slot #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_q <= RESET_VAL;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule : pipe_reg_slot

// File: rtl/pipe_reg.sv
// pipe_reg
//   Pipeline-stage register with valid/ready handshake, global stall and
//   synchronous flush. Sits between CPU stages (IF/ID, ID/EX, ...).
//
//   Build option:
//     PIPE_REG_SKID_EN defined   : two entries (main + skid); in_ready is
//                                  a function of state flops and ld only,
//                                  so out_ready has no comb path upstream.
//     PIPE_REG_SKID_EN undefined : single entry; in_ready is combinational
//                                  from downstream ready.
//
//   Parameters:
//     WIDTH     : payload width
//     RESET_VAL : out_data value after reset
//   Ports:
//     clk   : rising-edge clock
//     rst   : async active-high reset
//     ld    : stage enable, 0 = stall (no transfers, state frozen)
//     flush : synchronous squash of all held entries (wins over everything)
//     up    : upstream channel   (in_valid / in_ready / in_data)
//     dn    : downstream channel (out_valid / out_ready / out_data)
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic       flush,
  pipe_reg_if.slave  up,
  pipe_reg_if.master dn
);

  pipe_state_e      r_state;
  pipe_state_e      w_state_nxt;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_ld;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;

`ifdef PIPE_REG_SKID_EN
  logic             w_skid_ld;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_skid_q;
`endif

  // ---------------------------------------------------------------------
  // Handshake. Stall (ld=0) masks both sides so no transfer can happen
  // and the FSM below sees neither transfer.
  // ---------------------------------------------------------------------
  assign w_out_valid = ld & (r_state != PIPE_EMPTY);

`ifdef PIPE_REG_SKID_EN
  // Registered-only ready: the skid entry absorbs the one beat that is
  // in flight when downstream drops ready.
  assign w_in_ready = ld & (r_state != PIPE_FULL);
`else
  // Single entry: can only take a beat if empty or the held beat leaves
  // this same cycle.
  assign w_in_ready = ld & ((r_state == PIPE_EMPTY) | dn.ready);
`endif

  assign w_in_xfer  = up.valid & w_in_ready;
  assign w_out_xfer = w_out_valid & dn.ready;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= PIPE_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------
  // Next state and data-load controls. Flush drops every valid and any
  // coincident input beat, but leaves the data registers untouched so
  // out_data keeps showing the last main value.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
`ifdef PIPE_REG_SKID_EN
    w_skid_ld        = 1'b0;
    w_main_from_skid = 1'b0;
`endif
    if (flush) begin
      w_state_nxt = PIPE_EMPTY;
    end else begin
      case (r_state)
        PIPE_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = PIPE_BUSY;
            w_main_ld   = 1'b1;
          end
        end
        PIPE_BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            // pass-through: old beat leaves, new beat replaces it
            w_main_ld = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = PIPE_EMPTY;
          end
`ifdef PIPE_REG_SKID_EN
          else if (w_in_xfer) begin
            // downstream stalled: park the new beat behind main
            w_state_nxt = PIPE_FULL;
            w_skid_ld   = 1'b1;
          end
`endif
        end
`ifdef PIPE_REG_SKID_EN
        PIPE_FULL: begin
          // in_ready is low here, so only the drain side can move
          if (w_out_xfer) begin
            w_state_nxt      = PIPE_BUSY;
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
`endif
        default: w_state_nxt = PIPE_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Data path
  // ---------------------------------------------------------------------
`ifdef PIPE_REG_SKID_EN
  assign w_main_d = w_main_from_skid ? w_skid_q : up.data;

  pipe_reg_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .i_ld (w_skid_ld),
    .i_d  (up.data),
    .o_q  (w_skid_q)
  );
`else
  assign w_main_d = up.data;
`endif

  pipe_reg_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_ld (w_main_ld),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  // ---------------------------------------------------------------------
  // Outputs. out_data is always the main register, so it is stable while
  // a beat waits for downstream.
  // ---------------------------------------------------------------------
  assign up.ready = w_in_ready;
  assign dn.valid = w_out_valid;
  assign dn.data  = w_main_q;

endmodule : pipe_reg

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg
//   Scoreboard bench for pipe_reg. The reference model is an ordered queue
//   of accepted beats bounded by the stage capacity (1, or 2 with
//   PIPE_REG_SKID_EN). Handshake expectations are derived from the queue
//   occupancy; accepted beats are pushed, emitted beats are popped and
//   compared. Inputs change 1 time unit after the rising edge; the monitor
//   samples on the falling edge.
module tb_pipe_reg;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ld    = 1'b1;
  logic flush = 1'b0;

  pipe_reg_if #(.WIDTH(W)) up ();
  pipe_reg_if #(.WIDTH(W)) dn ();

  pipe_reg #(
    .WIDTH     (W),
    .RESET_VAL (32'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .flush (flush),
    .up    (up),
    .dn    (dn)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_err   = 0;
  int acc_cnt = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_hold = '0;

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic e_ov, e_ir, ixf, oxf;
    if (rst) begin
      sb_q.delete();
      exp_hold = '0;
    end else begin
      e_ov = ld && (sb_q.size() > 0);
`ifdef PIPE_REG_SKID_EN
      e_ir = ld && (sb_q.size() < 2);
`else
      e_ir = ld && ((sb_q.size() == 0) || (dn.ready === 1'b1));
`endif
      chk1("out_valid", dn.valid, e_ov);
      chk1("in_ready", up.ready, e_ir);
      chkw("out_data", dn.data, (sb_q.size() > 0) ? sb_q[0] : exp_hold);
      ixf = (up.valid === 1'b1) && e_ir;
      oxf = e_ov && (dn.ready === 1'b1);
      if (!flush) begin
        if (oxf) exp_hold = sb_q.pop_front();
        if (ixf) begin
          sb_q.push_back(up.data);
          acc_cnt++;
        end
      end else begin
        sb_q.delete();
      end
      if (sb_q.size() > 0) exp_hold = sb_q[0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int c;
    up.valid = 1'b0;
    up.data  = '0;
    dn.ready = 1'b0;

    // reset state
    #2;
    chk1("rst out_valid", dn.valid, 1'b0);
    chkw("rst out_data", dn.data, 32'h0);
    chk1("rst in_ready", up.ready, 1'b1);
    step();
    rst = 1'b0;

    // async reset while BUSY holding 00A0
    up.valid = 1'b1; up.data = 32'h00A0;
    step();
    up.valid = 1'b0;
    chk1("busy out_valid", dn.valid, 1'b1);
    chkw("busy out_data", dn.data, 32'h00A0);
    #2 rst = 1'b1;
    #1;
    chk1("midrst out_valid", dn.valid, 1'b0);
    chkw("midrst out_data", dn.data, 32'h0);
    chk1("midrst in_ready", up.ready, 1'b1);
    step();
    rst = 1'b0;
    step();

    // streaming 1..8 with out_ready high
    dn.ready = 1'b1;
    b = acc_cnt;
    c = 0;
    while ((acc_cnt - b) < 8 && c < 50) begin
      up.valid = 1'b1;
      up.data  = 32'(1 + acc_cnt - b);
      step();
      c++;
    end
    chk1("stream no stall", (c == 8), 1'b1);
    up.valid = 1'b0;
    repeat (3) step();

    // backpressure: out_ready low for 3 cycles mid-stream
    b = acc_cnt;
    c = 0;
    while ((acc_cnt - b) < 12 && c < 60) begin
      dn.ready = !(c >= 4 && c < 7);
      up.valid = 1'b1;
      up.data  = 32'h10 + 32'(acc_cnt - b);
      step();
      c++;
    end
    up.valid = 1'b0;
    dn.ready = 1'b1;
    repeat (4) step();

    // stall while BUSY with 00A0
    dn.ready = 1'b0;
    up.valid = 1'b1; up.data = 32'h00A0;
    step();
    up.valid = 1'b0;
    ld = 1'b0;
    step();
    step();
    chk1("stall out_valid", dn.valid, 1'b0);
    chk1("stall in_ready", up.ready, 1'b0);
    ld = 1'b1;
    #1;
    chk1("unstall out_valid", dn.valid, 1'b1);
    chkw("unstall out_data", dn.data, 32'h00A0);
    dn.ready = 1'b1;
    repeat (3) step();

    // flush with coincident DEAD beat
    dn.ready = 1'b0;
    up.valid = 1'b1; up.data = 32'h11;
    step();
    up.data = 32'h22;
    step();
    up.data = 32'hDEAD;
    flush = 1'b1;
    step();
    flush = 1'b0;
    up.valid = 1'b0;
    chk1("flush out_valid", dn.valid, 1'b0);
    chkw("flush out_data", dn.data, 32'h11);
    dn.ready = 1'b1;
    repeat (4) step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ld       = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      up.valid = $urandom_range(0, 1) == 1;
      up.data  = $urandom;
      dn.ready = ($urandom_range(0, 3) != 0);
      step();
    end
    ld = 1'b1; flush = 1'b0; up.valid = 1'b0; dn.ready = 1'b1;
    repeat (4) step();
    chk1("drained", (sb_q.size() == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_reg
